// File: rtl/rede_pkg.sv
// rede_pkg: shared constants and types for the rede output path.
//   NUBITS       processor output word width (signed)
//   NUIOOU       output slots per frame
//   FCNT_W       width of the pushed-frame counter
//   rede_word_t  one signed output word
//   rede_frame_t one frame of NUIOOU words, slot k at index k
package rede_pkg;
  localparam int NUBITS = 31;
  localparam int NUIOOU = 4;
  localparam int FCNT_W = 16;

  typedef logic signed [NUBITS-1:0] rede_word_t;
  typedef rede_word_t [NUIOOU-1:0] rede_frame_t;
endpackage

// File: rtl/rcol_fifo.sv
// rcol_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst  clock and synchronous active-high reset
//   i_push    write i_data (caller only pushes when not full, or full with a pop)
//   i_data    write data
//   i_pop     consume the head entry (ignored when empty)
//   o_data    head entry, zero when empty
//   o_empty   no entries
//   o_full    DEPTH entries held
module rcol_fifo #(
  parameter int W     = 124,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] r_mem [DEPTH];
  // Extra MSB on each pointer separates full from empty when the indices match.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // When full with a simultaneous pop, the write slot is the head slot;
      // the head is read combinationally this cycle, so overwriting is safe.
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
endmodule

// File: rtl/rede_out_collector.sv
// rede_out_collector: gathers the rede processor's per-slot output words into
// frames and queues completed frames toward a valid/ready consumer.
//   clk, rst   clock and synchronous active-high reset
//   io_out     signed output word from the processor
//   out_en     one-hot slot write strobe
//   frm_data   head frame, slot k at [k*NUBITS +: NUBITS]
//   frm_valid  frame queue not empty
//   frm_ready  consumer accepts the head frame
//   frm_cnt    frames pushed into the queue, wraps
//   ovf        sticky: a completed frame was dropped on a full queue
//   err        sticky: multi-hot strobe, duplicate slot, or order violation
// Build option RCOL_ORDER_CHECK_EN: slots must arrive 0..NUIOOU-1 in order;
// a violation discards the partial frame (a slot-0 write restarts the frame).
module rede_out_collector #(
  parameter int NUBITS = rede_pkg::NUBITS,
  parameter int NUIOOU = rede_pkg::NUIOOU,
  parameter int FDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [NUBITS-1:0] io_out,
  input  logic [NUIOOU-1:0]        out_en,
  output logic [NUIOOU*NUBITS-1:0] frm_data,
  output logic                     frm_valid,
  input  logic                     frm_ready,
  output logic [15:0]              frm_cnt,
  output logic                     ovf,
  output logic                     err
);
  import rede_pkg::*;

  localparam int IW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NUBITS-1:0]        r_slot [NUIOOU];
  logic [NUIOOU-1:0]        r_mask;
  logic [FCNT_W-1:0]        r_frm_cnt;
  logic                     r_ovf;
  logic                     r_err;

  logic                     w_onehot;
  logic                     w_multi;
  logic                     w_dup;
  logic [IW-1:0]            w_idx;
  logic [NUIOOU-1:0]        w_mask_upd;
  logic [NUIOOU-1:0]        w_mask_nxt;
  logic                     w_complete;
  logic                     w_err_evt;
  logic [NUIOOU*NUBITS-1:0] w_frame;
  logic                     w_fifo_empty;
  logic                     w_fifo_full;
  logic                     w_pop;
  logic                     w_push_ok;

  assign w_onehot   = (out_en != '0) && ((out_en & (out_en - 1'b1)) == '0);
  assign w_multi    = (out_en != '0) && !w_onehot;
  assign w_dup      = w_onehot && ((r_mask & out_en) != '0);
  assign w_mask_upd = r_mask | out_en;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NUIOOU; k++) begin
      if (out_en[k]) w_idx = IW'(k);
    end
  end

`ifdef RCOL_ORDER_CHECK_EN
  logic [IW-1:0] r_exp;
  logic [IW-1:0] w_exp_nxt;
  logic          w_order_bad;

  assign w_order_bad = w_onehot && (w_idx != r_exp);
  assign w_complete  = w_onehot && !w_order_bad && (w_idx == IW'(NUIOOU-1));
  assign w_err_evt   = w_multi || w_dup || w_order_bad;

  always_comb begin
    w_mask_nxt = r_mask;
    w_exp_nxt  = r_exp;
    if (w_complete) begin
      w_mask_nxt = '0;
      w_exp_nxt  = '0;
    end else if (w_order_bad) begin
      // Out-of-order write to slot 0 is treated as the start of a new frame.
      w_mask_nxt = (w_idx == '0) ? out_en : '0;
      w_exp_nxt  = (w_idx == '0) ? IW'(1) : '0;
    end else if (w_onehot) begin
      w_mask_nxt = w_mask_upd;
      w_exp_nxt  = r_exp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_exp <= '0;
    else     r_exp <= w_exp_nxt;
  end
`else
  assign w_complete = w_onehot && (w_mask_upd == '1);
  assign w_err_evt  = w_multi || w_dup;

  always_comb begin
    w_mask_nxt = r_mask;
    if (w_complete)    w_mask_nxt = '0;
    else if (w_onehot) w_mask_nxt = w_mask_upd;
  end
`endif

  // The completing word bypasses its slot register so it lands in the frame
  // pushed on the same edge.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUIOOU; k++) begin
      w_frame[k*NUBITS +: NUBITS] = (w_onehot && out_en[k]) ? io_out : r_slot[k];
    end
  end

  assign w_pop     = !w_fifo_empty && frm_ready;
  assign w_push_ok = w_complete && (!w_fifo_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask    <= '0;
      r_frm_cnt <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      for (int k = 0; k < NUIOOU; k++) r_slot[k] <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      if (w_onehot)                 r_slot[w_idx] <= io_out;
      if (w_push_ok)                r_frm_cnt     <= r_frm_cnt + 1'b1;
      if (w_complete && !w_push_ok) r_ovf         <= 1'b1;
      if (w_err_evt)                r_err         <= 1'b1;
    end
  end

  rcol_fifo #(
    .W     (NUIOOU*NUBITS),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_data  (w_frame),
    .i_pop   (w_pop),
    .o_data  (frm_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign frm_valid = !w_fifo_empty;
  assign frm_cnt   = r_frm_cnt;
  assign ovf       = r_ovf;
  assign err       = r_err;
endmodule

// File: tb/tb_rede_out_collector.sv
// tb_rede_out_collector: scoreboard bench for rede_out_collector.
// Build option RCOL_ORDER_CHECK_EN enables the slot-order scenario.
module tb_rede_out_collector;
  localparam int NB = 31;
  localparam int NS = 4;
  localparam int FD = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [NB-1:0] io_out = '0;
  logic [NS-1:0]        out_en = '0;
  logic [NS*NB-1:0]     frm_data;
  logic                 frm_valid;
  logic                 frm_ready = 1'b0;
  logic [15:0]          frm_cnt;
  logic                 ovf;
  logic                 err;

  rede_out_collector #(.NUBITS(NB), .NUIOOU(NS), .FDEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_out    (io_out),
    .out_en    (out_en),
    .frm_data  (frm_data),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_cnt   (frm_cnt),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [NS*NB-1:0] exp_q [$];
  logic [NB-1:0]    m_slot [NS];
  logic [NS-1:0]    m_mask;
  logic [15:0]      m_cnt;
  logic             m_ovf;
  logic             m_err;
  int               m_exp;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_mask = '0;
    m_cnt  = '0;
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    m_exp  = 0;
    for (int k = 0; k < NS; k++) m_slot[k] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; out_en = '0; io_out = '0; frm_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: compare outputs against the model, drive inputs, advance model.
  task automatic step(input logic [NS-1:0] en, input logic [NB-1:0] w, input logic rdy);
    logic [NS*NB-1:0] frame;
    bit pop, complete, bad;
    int k;
    out_en = en; io_out = w; frm_ready = rdy;
    check("valid", frm_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("data", frm_data, exp_q[0]);
    check("cnt", frm_cnt, m_cnt);
    check("ovf", ovf, m_ovf);
    check("err", err, m_err);
    pop = (exp_q.size() != 0) && rdy;
    complete = 1'b0;
    if ($countones(en) > 1) m_err = 1'b1;
    else if ($countones(en) == 1) begin
      k = 0;
      for (int i = 0; i < NS; i++) if (en[i]) k = i;
      if (m_mask[k]) m_err = 1'b1;
      m_slot[k] = w;
`ifdef RCOL_ORDER_CHECK_EN
      bad = (k != m_exp);
      if (bad) begin
        m_err  = 1'b1;
        m_mask = (k == 0) ? en : '0;
        m_exp  = (k == 0) ? 1 : 0;
      end else begin
        m_mask = m_mask | en;
        m_exp  = m_exp + 1;
        complete = (k == NS-1);
      end
`else
      bad = 1'b0;
      m_mask = m_mask | en;
      complete = (m_mask == '1) && !bad;
`endif
    end
    if (complete) begin
      for (int i = 0; i < NS; i++) frame[i*NB +: NB] = m_slot[i];
      m_mask = '0;
      m_exp  = 0;
    end
    if (pop) void'(exp_q.pop_front());
    if (complete) begin
      if (exp_q.size() < FD) begin
        exp_q.push_back(frame);
        m_cnt++;
      end else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic rdy_last);
    for (int i = 0; i < NS; i++)
      step(NS'(1) << i, NB'($urandom), (i == NS-1) ? rdy_last : 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step('0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
    step('0, '0, 1'b0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // reset values
    check("rst_data", frm_data, '0);
    check("rst_valid", frm_valid, 1'b0);
    check("rst_cnt", frm_cnt, 16'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_err", err, 1'b0);

    // bit-exact frame, valid the cycle after the 4th write
    step(4'b0001, 31'd5, 1'b0);
    step(4'b0010, 31'h7FFF_FFFF, 1'b0);
    step(4'b0100, 31'h3FFF_FFFF, 1'b0);
    step(4'b1000, 31'h4000_0000, 1'b0);
    check("lat_valid", frm_valid, 1'b1);
    check("lat_cnt", frm_cnt, 16'd1);
    check("slot0", frm_data[0*NB +: NB], 31'd5);
    check("slot1", frm_data[1*NB +: NB], 31'h7FFF_FFFF);
    check("slot2", frm_data[2*NB +: NB], 31'h3FFF_FFFF);
    check("slot3", frm_data[3*NB +: NB], 31'h4000_0000);
    drain();

    // queue full, consumer ready on the completion edge: push accepted
    send_frame(1'b0);
    send_frame(1'b0);
    send_frame(1'b1);
    check("full_pop_ovf", ovf, 1'b0);
    check("full_pop_cnt", frm_cnt, 16'd4);
    drain();

    // three frames with no consumer: third dropped
    do_reset();
    send_frame(1'b0);
    send_frame(1'b0);
    send_frame(1'b0);
    check("ovf_set", ovf, 1'b1);
    check("ovf_cnt", frm_cnt, 16'd2);
    drain();

    // multi-hot strobe: err, mask unchanged
    do_reset();
    step(4'b0001, 31'd11, 1'b0);
    step(4'b0011, 31'd99, 1'b0);
    check("multi_err", err, 1'b1);
    step(4'b0010, 31'd12, 1'b0);
    step(4'b0100, 31'd13, 1'b0);
    step(4'b1000, 31'd14, 1'b0);
    check("multi_frame", frm_valid, 1'b1);
    check("multi_s0", frm_data[0 +: NB], 31'd11);
    drain();

    // duplicate slot 2 write (no order option): last write wins
`ifndef RCOL_ORDER_CHECK_EN
    do_reset();
    step(4'b0001, 31'd1, 1'b0);
    step(4'b0010, 31'd2, 1'b0);
    step(4'b0100, 31'd7, 1'b0);
    step(4'b0100, 31'd9, 1'b0);
    check("dup_err", err, 1'b1);
    step(4'b1000, 31'd3, 1'b0);
    check("dup_slot2", frm_data[2*NB +: NB], 31'd9);
    drain();
`endif

    // reset mid-frame discards partial frame
    do_reset();
    step(4'b0001, 31'd21, 1'b0);
    step(4'b0010, 31'd22, 1'b0);
    do_reset();
    step('0, '0, 1'b0);
    check("midrst_valid", frm_valid, 1'b0);
    send_frame(1'b0);
    check("midrst_cnt", frm_cnt, 16'd1);
    drain();

`ifdef RCOL_ORDER_CHECK_EN
    do_reset();
    step(4'b0001, 31'd31, 1'b0);
    step(4'b0100, 31'd32, 1'b0);
    check("order_err", err, 1'b1);
    check("order_novalid", frm_valid, 1'b0);
    send_frame(1'b0);
    check("order_cnt", frm_cnt, 16'd1);
    drain();
`endif

    // back-to-back random frames with an always-ready consumer
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(1'b1);
    drain();
    check("b2b_cnt", frm_cnt, 16'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
